// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared RV32I decode constants and control-word layout
// Contents: opcode constants, immediate-select codes, ctrl_word_t field layout.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I      = 3'b000;
    localparam logic [2:0] IMM_ISHIFT = 3'b001;
    localparam logic [2:0] IMM_SB     = 3'b010;
    localparam logic [2:0] IMM_U      = 3'b011;
    localparam logic [2:0] IMM_J      = 3'b100;
    localparam logic [2:0] IMM_NONE   = 3'b111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic branch;
        logic jump;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NONE = '0;

endpackage

// File: rtl/id_ctrl_sequencer_if.sv
// rtl/id_ctrl_sequencer_if.sv - IF/ID-to-ID/EX control bus
// master: drives instr_in/if_valid/flush; slave (the sequencer) drives decode outputs.
interface id_ctrl_sequencer_if;
    logic [31:0] instr_in;
    logic        if_valid;
    logic        flush;
    logic [2:0]  immi_sel;
    logic [31:0] instr_out;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        id_valid;
    logic        hold_ifid;
    logic        illegal;

    modport master (
        output instr_in, if_valid, flush,
        input  immi_sel, instr_out, reg_write, mem_read, mem_write, alu_src,
               branch, jump, id_valid, hold_ifid, illegal
    );

    modport slave (
        input  instr_in, if_valid, flush,
        output immi_sel, instr_out, reg_write, mem_read, mem_write, alu_src,
               branch, jump, id_valid, hold_ifid, illegal
    );
endinterface

// File: rtl/id_decode_comb.sv
// rtl/id_decode_comb.sv - combinational opcode/funct3 decoder
// In: opcode, funct3. Out: control word, immediate select, rs1/rs2 usage, illegal.
module id_decode_comb
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output ctrl_word_t ctrl,
    output logic [2:0] immi_sel,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       illegal
);

    always_comb begin
        ctrl     = CTRL_NONE;
        immi_sel = IMM_NONE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                immi_sel       = IMM_I;
                uses_rs1       = 1'b1;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                immi_sel       = IMM_SB;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                immi_sel    = IMM_SB;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                // funct3 001/101 are the shift forms whose imm field is shamt
                immi_sel       = (funct3[1:0] == 2'b01) ? IMM_ISHIFT : IMM_I;
                uses_rs1       = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                immi_sel       = IMM_U;
            end
            OPC_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                immi_sel       = IMM_J;
            end
            OPC_JALR: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                immi_sel       = IMM_I;
                uses_rs1       = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ctrl_sequencer.sv
// rtl/id_ctrl_sequencer.sv - ID-stage controller: decode, load-use stall, flush
// Ports: clk, rst (async active-high), bus (slave modport): instr_in/if_valid/flush in;
// registered immi_sel/instr_out/control/id_valid/illegal out; combinational hold_ifid out.
module id_ctrl_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ctrl_sequencer_if.slave   bus
);

    ctrl_word_t dec_ctrl;
    logic [2:0] dec_immi_sel;
    logic       dec_uses_rs1;
    logic       dec_uses_rs2;
    logic       dec_illegal;

    id_decode_comb u_decode (
        .opcode   (bus.instr_in[6:0]),
        .funct3   (bus.instr_in[14:12]),
        .ctrl     (dec_ctrl),
        .immi_sel (dec_immi_sel),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    ctrl_word_t  ctrl_q;
    logic [2:0]  immi_sel_q;
    logic [31:0] instr_q;
    logic        id_valid_q;
    logic        illegal_q;
    logic [4:0]  ex_load_rd;
    logic        ex_is_load;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       load_use;
    logic       issue;

    assign rs1 = bus.instr_in[19:15];
    assign rs2 = bus.instr_in[24:20];

    // Operand-usage flags keep U/J immediates and non-rs2 formats from
    // matching on bits that are not register fields.
    assign load_use = bus.if_valid && ex_is_load && (ex_load_rd != 5'd0) &&
                      ((dec_uses_rs1 && (rs1 == ex_load_rd)) ||
                       (dec_uses_rs2 && (rs2 == ex_load_rd)));

    assign issue = bus.if_valid && !bus.flush && !load_use && !dec_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= CTRL_NONE;
            immi_sel_q <= IMM_NONE;
            instr_q    <= NOP_INSTR;
            id_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            ex_load_rd <= 5'd0;
            ex_is_load <= 1'b0;
        end else if (issue) begin
            ctrl_q     <= dec_ctrl;
            immi_sel_q <= dec_immi_sel;
            instr_q    <= bus.instr_in;
            id_valid_q <= 1'b1;
            illegal_q  <= 1'b0;
            ex_load_rd <= bus.instr_in[11:7];
            ex_is_load <= dec_ctrl.mem_read;
        end else begin
            // Bubble; clearing ex_is_load guarantees a stall never repeats.
            ctrl_q     <= CTRL_NONE;
            immi_sel_q <= IMM_NONE;
            instr_q    <= NOP_INSTR;
            id_valid_q <= 1'b0;
            illegal_q  <= bus.if_valid && !bus.flush && dec_illegal;
            ex_load_rd <= 5'd0;
            ex_is_load <= 1'b0;
        end
    end

    assign bus.hold_ifid = load_use && !bus.flush && !rst;
    assign bus.immi_sel  = immi_sel_q;
    assign bus.instr_out = instr_q;
    assign bus.reg_write = ctrl_q.reg_write;
    assign bus.mem_read  = ctrl_q.mem_read;
    assign bus.mem_write = ctrl_q.mem_write;
    assign bus.alu_src   = ctrl_q.alu_src;
    assign bus.branch    = ctrl_q.branch;
    assign bus.jump      = ctrl_q.jump;
    assign bus.id_valid  = id_valid_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: doc/id_ctrl_sequencer.md
Name: id_ctrl_sequencer

Overview:
- Instruction-decode-stage controller for the pipelined RV32I core.
- Decodes the IF/ID instruction into the immediate-select code for the sign-extension unit and the ID/EX control word, and registers both into ID/EX.
- Detects load-use hazards: holds IF/ID and inserts a one-cycle bubble.
- Applies branch/jump flushes from EX.

Parameters:
- NOP_INSTR, 32'h0000_0013, instruction word presented on INSTR_OUT for bubbles and flushes (addi x0,x0,0)

Ports:
- CLK  input  1  clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- INSTR_IN  input  32  instruction from the IF/ID register
- IF_VALID  input  1  INSTR_IN holds a real instruction
- FLUSH  input  1  taken branch/jump resolved in EX; kill the ID instruction
- IMMI_SEL  output  3  registered immediate-select code for the sign-extension unit
- INSTR_OUT  output  32  registered instruction word for the sign-extension unit and ID/EX
- REG_WRITE  output  1  registered control: destination register written
- MEM_READ  output  1  registered control: load
- MEM_WRITE  output  1  registered control: store
- ALU_SRC  output  1  registered control: ALU operand B is the immediate
- BRANCH  output  1  registered control: conditional branch
- JUMP  output  1  registered control: JAL/JALR
- ID_VALID  output  1  registered: the ID/EX slot holds a real instruction
- HOLD_IFID  output  1  combinational: hold the PC and IF/ID this cycle
- ILLEGAL  output  1  registered: the decoded opcode is unsupported

Behaviour:
- IMMI_SEL encoding:
  - 000 I-type (loads, OP-IMM arithmetic, JALR)
  - 001 I-shift (SLLI/SRLI/SRAI)
  - 010 S-type and B-type
  - 011 U-type (LUI, AUIPC)
  - 100 J-type (JAL)
  - 111 none (R-type, bubble)
- Decode depends on opcode INSTR_IN[6:0]. For OP-IMM it also uses funct3 INSTR_IN[14:12]: funct3 001 and 101 select I-shift.
- Control-word contents:
  - Loads: MEM_READ, REG_WRITE and ALU_SRC set.
  - Stores: MEM_WRITE and ALU_SRC set.
  - Branches: BRANCH set.
  - JAL/JALR: JUMP and REG_WRITE set.
  - R-type: REG_WRITE set.
  - OP-IMM/LUI/AUIPC: REG_WRITE and ALU_SRC set.
- Any other opcode with IF_VALID=1 registers a bubble and sets ILLEGAL=1 for one cycle.
- Hazard tracking register: EX_LOAD_RD[4:0] plus EX_IS_LOAD. It is loaded each cycle from the instruction entering ID/EX; a bubble clears EX_IS_LOAD.
- Load-use condition: IF_VALID & EX_IS_LOAD & EX_LOAD_RD≠0, and EX_LOAD_RD equals rs1 (INSTR_IN[19:15]) or rs2 (INSTR_IN[24:20]). The rs2 compare applies only to R/S/B formats; the rs1 compare does not apply to U/J formats.
- On load-use:
  - HOLD_IFID=1 for exactly one cycle.
  - A bubble is registered into ID/EX.
  - On the next cycle EX_IS_LOAD=0, so the same instruction issues normally. The stall lasts exactly one cycle and cannot repeat.
- Bubble means: all control outputs 0, ID_VALID=0, IMMI_SEL=111, INSTR_OUT=NOP_INSTR.
- IF_VALID=0 registers a bubble.
- Priority: FLUSH > load-use > normal decode.
  - FLUSH registers a bubble and forces HOLD_IFID=0, even when a load-use condition is present in the same cycle.
- Latency: one cycle from INSTR_IN to the registered outputs.
- Reset: RESET asserted at any time, including mid-stall, forces all registered outputs to the bubble values, clears ILLEGAL, EX_IS_LOAD and EX_LOAD_RD, and drives HOLD_IFID to 0 immediately.
- rd=x0 never causes a stall.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants: OPC_LOAD 0000011, OPC_OPIMM 0010011, OPC_STORE 0100011, OPC_BRANCH 1100011, OPC_OP 0110011, OPC_LUI 0110111, OPC_AUIPC 0010111, OPC_JAL 1101111, OPC_JALR 1100111
  - the IMMI_SEL encodings listed above
  - the control-word field layout
- One sub-module, id_decode_comb, is purely combinational: opcode/funct3 in, control word, IMMI_SEL and illegal flag out. id_ctrl_sequencer keeps the registers, the hazard compare and the priority logic.

Test Plan:
- Reset: assert RESET mid-stream → all outputs 0, IMMI_SEL=111, INSTR_OUT=32'h0000_0013 within the same cycle.
- Decode sweep: lw x5,8(x1) → next cycle MEM_READ=1, REG_WRITE=1, ALU_SRC=1, IMMI_SEL=000. sw → MEM_WRITE=1, IMMI_SEL=010. slli x3,x3,4 → IMMI_SEL=001. jal → JUMP=1, IMMI_SEL=100.
- Load-use: lw x5,0(x1) followed by add x6,x5,x2 → HOLD_IFID=1 for one cycle and one bubble (ID_VALID=0); add issues the next cycle and HOLD_IFID stays 0.
- No false stall:
  - lw x0,0(x1) followed by add x6,x0,x2 → no stall.
  - lw x5 followed by lui x5,1 → no stall (U-type has no rs1/rs2).
- Flush priority: lw x5 in EX and add x6,x5,x2 in ID with FLUSH=1 → HOLD_IFID=0, bubble registered, EX_IS_LOAD cleared.
- Illegal: opcode 1111111 with IF_VALID=1 → ILLEGAL=1 for one cycle with ID_VALID=0. IF_VALID=0 → bubble and ILLEGAL=0.
